sequence_generator: RTL and testbench
=====================================

# sequence_generator

Bit-serial pattern transmitter: on a start request it emits a fixed WIDTH-bit pattern MSB-first on a single-bit line, repeated a programmable number of times with idle gap bits between repetitions. It is the source-side counterpart of the team's single-bit sequence detectors. It drives their `in` input in loopback benches and on-chip test paths; the default pattern is 1011.

## Interface
- WIDTH, 4, pattern length in bits (≥1)
- PATTERN, 4'b1011, pattern transmitted MSB first
- GAP, 2, idle cycles (out=0, out_valid=0) between repetitions (≥0)
- CNT_W, 8, width of repetition count
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only in IDLE
- reps  input  CNT_W  repetition count, latched when start is accepted
- abort  input  1  terminate current transfer
- out  output  1  serial data bit
- out_valid  output  1  out carries a pattern bit this cycle
- busy  output  1  transfer in progress (SHIFT, GAP, DONE)
- done  output  1  single-cycle completion pulse

## Operation
- FSM states: IDLE, SHIFT, GAP, DONE. Outputs are registered, decoded from state and counters (Moore).
- IDLE: out=0, out_valid=0, busy=0, done=0.
  - abort=1 → stay IDLE; start is ignored.
  - Else start=1 → latch reps into rep_cnt, set bit_idx=WIDTH-1; go to SHIFT if reps≠0, else go to DONE.
- SHIFT: out=PATTERN[bit_idx], out_valid=1, busy=1.
  - bit_idx>0 → bit_idx decrements.
  - bit_idx==0 → rep_cnt decrements.
    - rep_cnt was 1 → go to DONE.
    - Otherwise, GAP>0 → go to GAP with gap_cnt=GAP-1.
    - Otherwise, GAP==0 → stay in SHIFT, bit_idx=WIDTH-1 (back-to-back patterns).
- GAP: out=0, out_valid=0, busy=1.
  - gap_cnt==0 → go to SHIFT, bit_idx=WIDTH-1.
  - Otherwise gap_cnt decrements.
- DONE: done=1, busy=1, out=0, out_valid=0; unconditionally go to IDLE next cycle.
- abort in SHIFT or GAP has priority over all progression: go to DONE next cycle. The pattern in flight is truncated and the remaining reps are discarded.
- abort in DONE: no effect.
- start outside IDLE: ignored, not queued.
- Widths:
  - rep_cnt is CNT_W unsigned; maximum 2^CNT_W-1 repetitions.
  - bit_idx is $clog2(WIDTH) bits; use 1 bit when WIDTH=1.
  - gap_cnt is $clog2(GAP+1) bits; it is absent and unused when GAP=0.
  - No counter wraps: every decrement is guarded by its ==0 check.

## Timing
- Reset (asynchronous, any state): state=IDLE, all counters=0, and out=out_valid=busy=done=0 immediately.
- Reset mid-transfer aborts silently: no done pulse.
- start accepted at edge k:
  - First pattern bit appears on out during cycle k+1 (latency 1).
  - Total busy cycles: reps·WIDTH + (reps-1)·GAP + 1 (DONE).
- reps=0: busy and done both high in cycle k+1; IDLE at k+2; out_valid never asserts.
- The earliest new start is accepted at the edge ending the DONE cycle's successor (IDLE). There is at least one IDLE cycle between transfers.
- abort sampled at edge m during SHIFT or GAP: DONE during cycle m+1, IDLE at m+2.

## Structure
- Shared package seq_gen_pkg:
  - state enum seq_gen_state_t (IDLE, SHIFT, GAP, DONE, 2-bit encoding);
  - constant DEFAULT_PATTERN = 4'b1011.
  - The detectors reuse this constant.
- Single module; no sub-module is warranted.
- State register, rep_cnt, bit_idx and gap_cnt live in one always_ff with async reset. Next-state and output decode go in always_comb.

## Test plan
- Default params, reps=1, start at edge 0 → out_valid cycles 1–4 with out=1,0,1,1; done=1 in cycle 5; busy cycles 1–5; IDLE in cycle 6.
- reps=2, GAP=2 → bits 1,0,1,1 in cycles 1–4; out=0 and out_valid=0 in cycles 5–6; bits 1,0,1,1 in cycles 7–10; done in cycle 11.
- Loopback: out drives a 1011 sequence detector (reset together), reps=3, GAP=2 → detector `detected` asserts exactly 3 times, each one cycle after the final '1' of a pattern.
- reps=0 → no out_valid; done and busy both high in cycle 1; IDLE in cycle 2.
- reps=5, abort after the second bit of repetition 2 → out_valid drops the next cycle; done pulses once; IDLE follows. start held high during the transfer has no effect.
- Async rst asserted mid-SHIFT between clock edges → all outputs 0 immediately and no done pulse. After release, start with reps=1 produces the full pattern from the first bit.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator and its matching sequence detectors.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_gen_state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/sequence_generator.sv
// Bit-serial pattern transmitter: sends PATTERN MSB-first reps times, GAP idle bits apart,
// then pulses done. Outputs are decoded from registered state and counters only.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = DEFAULT_PATTERN,
  parameter int              GAP     = 2,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  // Only meaningful when GAP > 0; the GAP==0 path never loads the gap counter.
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  seq_gen_state_t   state, state_n;
  logic [CNT_W-1:0] rep_cnt, rep_n;
  logic [BW-1:0]    bit_idx, bit_n;
  logic [GW-1:0]    gap_cnt, gap_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rep_cnt <= '0;
      bit_idx <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      rep_cnt <= rep_n;
      bit_idx <= bit_n;
      gap_cnt <= gap_n;
    end
  end

  // Abort wins over every progression step while a transfer is active.
  always_comb begin
    state_n = state;
    rep_n   = rep_cnt;
    bit_n   = bit_idx;
    gap_n   = gap_cnt;
    case (state)
      IDLE: begin
        if (!abort && start) begin
          rep_n   = reps;
          bit_n   = BIT_LAST;
          state_n = (reps != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n = DONE;
        end else if (bit_idx != '0) begin
          bit_n = bit_idx - 1'b1;
        end else begin
          rep_n = rep_cnt - 1'b1;
          if (rep_cnt == CNT_W'(1)) begin
            state_n = DONE;
          end else if (GAP > 0) begin
            state_n = seq_gen_pkg::GAP;
            gap_n   = GAP_LOAD;
          end else begin
            bit_n = BIT_LAST;
          end
        end
      end
      seq_gen_pkg::GAP: begin
        if (abort) begin
          state_n = DONE;
        end else if (gap_cnt == '0) begin
          state_n = SHIFT;
          bit_n   = BIT_LAST;
        end else begin
          gap_n = gap_cnt - 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    out       = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    if (state == SHIFT) begin
      out       = PATTERN[bit_idx];
      out_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator with a small 1011 detector on the loopback path.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] reps;
  logic       abort;
  logic       out, out_valid, busy, done;

  int tests = 0;
  int fails = 0;

  sequence_generator dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .reps     (reps),
    .abort    (abort),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference 1011 detector: flags during the cycle after the last pattern bit.
  logic [3:0] hist;
  logic       detected;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist <= '0;
    else     hist <= {hist[2:0], out};
  end
  assign detected = (hist == 4'b1011);

  function automatic logic [3:0] obs();
    return {busy, done, out_valid, out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; reps = '0;
    #2;
    tests++;
    if (obs() !== 4'b0000) begin
      fails++;
      $display("FAIL reset_state: got %b want %b", obs(), 4'b0000);
    end
    tick();
    rst = 1'b0;
    tick();
    tests++;
    if (obs() !== 4'b0000) begin
      fails++;
      $display("FAIL reset_idle: got %b want %b", obs(), 4'b0000);
    end
  endtask

  // Expected per-cycle vectors are {busy, done, out_valid, out}.
  task automatic test_single();
    logic [3:0] exp [1:6];
    exp = '{4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1100, 4'b0000};
    reps = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tests++;
      if (obs() !== exp[c]) begin
        fails++;
        $display("FAIL single c%0d: got %b want %b", c, obs(), exp[c]);
      end
      tick();
    end
  endtask

  task automatic test_gap();
    logic [3:0] exp [1:12];
    exp = '{4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1000, 4'b1000,
            4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1100, 4'b0000};
    reps = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tests++;
      if (obs() !== exp[c]) begin
        fails++;
        $display("FAIL gap c%0d: got %b want %b", c, obs(), exp[c]);
      end
      tick();
    end
  endtask

  task automatic test_reps0();
    logic [3:0] exp [1:3];
    exp = '{4'b1100, 4'b0000, 4'b0000};
    reps = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tests++;
      if (obs() !== exp[c]) begin
        fails++;
        $display("FAIL reps0 c%0d: got %b want %b", c, obs(), exp[c]);
      end
      tick();
    end
  endtask

  task automatic test_loopback();
    int want [0:2];
    int det_n;
    want = '{5, 11, 17};
    det_n = 0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
    reps = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (detected) begin
        tests++;
        if (det_n >= 3 || c != want[det_n]) begin
          fails++;
          $display("FAIL loopback_when: detection %0d at c%0d want c%0d", det_n, c,
                   (det_n < 3) ? want[det_n] : -1);
        end
        det_n++;
      end
      tick();
    end
    tests++;
    if (det_n != 3) begin
      fails++;
      $display("FAIL loopback_count: got %0d want 3", det_n);
    end
  endtask

  task automatic test_abort();
    logic [3:0] exp [1:11];
    exp = '{4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1000, 4'b1000,
            4'b1011, 4'b1010, 4'b1100, 4'b0000, 4'b0000};
    reps = 8'd5; start = 1'b1;
    tick();
    for (int c = 1; c <= 11; c++) begin
      tests++;
      if (obs() !== exp[c]) begin
        fails++;
        $display("FAIL abort c%0d: got %b want %b", c, obs(), exp[c]);
      end
      abort = (c == 8);
      start = (c < 9);
      tick();
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [3:0] exp [1:6];
    exp = '{4'b1011, 4'b1010, 4'b1011, 4'b1011, 4'b1100, 4'b0000};
    reps = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #3 rst = 1'b1;
    #1;
    tests++;
    if (obs() !== 4'b0000) begin
      fails++;
      $display("FAIL async_rst_immediate: got %b want %b", obs(), 4'b0000);
    end
    tick();
    #3 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (obs() !== 4'b0000) begin
        fails++;
        $display("FAIL async_rst_quiet c%0d: got %b want %b", c, obs(), 4'b0000);
      end
    end
    reps = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tests++;
      if (obs() !== exp[c]) begin
        fails++;
        $display("FAIL after_rst c%0d: got %b want %b", c, obs(), exp[c]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_reps0();
    test_loopback();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
